// File: rtl/snum_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master drives the request; the slave (converter) returns status and digits.
interface snum_bcd_seq_if;
  logic       start;
  logic [7:0] value;
  logic       signed_mode;
  logic       busy;
  logic       done;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic       neg;
  logic [3:0] en;

  modport master (
    output start,
    output value,
    output signed_mode,
    input  busy,
    input  done,
    input  ones,
    input  tens,
    input  hundreds,
    input  neg,
    input  en
  );

  modport slave (
    input  start,
    input  value,
    input  signed_mode,
    output busy,
    output done,
    output ones,
    output tens,
    output hundreds,
    output neg,
    output en
  );
endinterface

// File: rtl/snum_bcd_seq.sv
// Sequential 8-bit binary (signed or unsigned) to sign + 3-digit BCD converter.
// Iterative shift-add-3 datapath; registered digits with leading-zero blanking enables.
module snum_bcd_seq #(
  parameter int unsigned ITER = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  snum_bcd_seq_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StConv = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] LastIter = 3'(ITER - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  mag_q, mag_d;
  logic [11:0] bcd_q, bcd_d;
  logic        neg_int_q, neg_int_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  hundreds_q, hundreds_d;
  logic        neg_q, neg_d;
  logic [3:0]  en_q, en_d;

  logic [11:0] bcd_adj;
  logic        is_neg_in;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  assign bcd_adj   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  assign is_neg_in = bus.signed_mode & bus.value[7];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    neg_int_d  = neg_int_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;
    neg_d      = neg_q;
    en_d       = en_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mag_d     = is_neg_in ? (~bus.value + 8'd1) : bus.value;
          neg_int_d = is_neg_in;
          bcd_d     = '0;
          cnt_d     = '0;
          state_d   = StConv;
        end
      end
      StConv: begin
        {bcd_d, mag_d} = {bcd_adj[10:0], mag_q, 1'b0};
        cnt_d          = cnt_q + 3'd1;
        if (cnt_q == LastIter) begin
          // Load the result on the final shift so it is visible alongside done.
          state_d    = StDone;
          ones_d     = bcd_d[3:0];
          tens_d     = bcd_d[7:4];
          hundreds_d = bcd_d[11:8];
          neg_d      = neg_int_q & (bcd_d != 12'd0);
          en_d       = {neg_d,
                        bcd_d[11:8] != 4'd0,
                        bcd_d[11:4] != 8'd0,
                        1'b1};
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      neg_int_q  <= 1'b0;
      ones_q     <= '0;
      tens_q     <= '0;
      hundreds_q <= '0;
      neg_q      <= 1'b0;
      en_q       <= 4'b0001;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      neg_int_q  <= neg_int_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
      neg_q      <= neg_d;
      en_q       <= en_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.ones     = ones_q;
  assign bus.tens     = tens_q;
  assign bus.hundreds = hundreds_q;
  assign bus.neg      = neg_q;
  assign bus.en       = en_q;

endmodule

// File: tb/tb_snum_bcd_seq.sv
// Directed self-checking bench for snum_bcd_seq: conversion results, cycle timing,
// ignored starts while busy, mid-conversion reset and output hold.
module tb_snum_bcd_seq;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  // Expected held result: {neg, en[3:0], hundreds, tens, ones}
  logic [16:0] cur;
  logic [18:0] obs;

  snum_bcd_seq_if bus ();

  snum_bcd_seq #(
    .ITER (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.busy, bus.done, bus.neg, bus.en, bus.hundreds, bus.tens, bus.ones};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed {busy,done,neg,en,h,t,o}=%h expected=%h", tag, o, e);
    end
  endtask

  // Starts in an idle cycle, ends in cycle 10 (idle again, next start allowed).
  task automatic run_conv(input logic [7:0] v, input logic sm, input logic [16:0] res,
                          input string tag);
    bus.value       = v;
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.value       = ~v;
    bus.signed_mode = ~sm;
    for (int c = 1; c <= 8; c++) begin
      chk({tag, "_busy"}, obs, {2'b10, cur});
      tick();
    end
    cur = res;
    chk({tag, "_done"}, obs, {2'b11, cur});
    tick();
    chk({tag, "_hold"}, obs, {2'b00, cur});
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b1;
    bus.value       = 8'h55;
    bus.signed_mode = 1'b0;
    tick();
    tick();
    cur = {1'b0, 4'b0001, 12'h000};
    chk("reset", obs, {2'b00, cur});
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();
    chk("idle", obs, {2'b00, cur});

    run_conv(8'd0,   1'b1, {1'b0, 4'b0001, 12'h000}, "zero");
    run_conv(8'hFF,  1'b1, {1'b1, 4'b1001, 12'h001}, "m1");
    run_conv(8'hFF,  1'b0, {1'b0, 4'b0111, 12'h255}, "u255");
    run_conv(8'h80,  1'b1, {1'b1, 4'b1111, 12'h128}, "m128");
    run_conv(8'd99,  1'b0, {1'b0, 4'b0011, 12'h099}, "u99");
    run_conv(8'h9C,  1'b1, {1'b1, 4'b1111, 12'h100}, "m100");
    run_conv(8'h7F,  1'b1, {1'b0, 4'b0111, 12'h127}, "p127");

    // Starts during CONV (cycle 3) and DONE (cycle 9) must be ignored.
    bus.value       = 8'd42;
    bus.signed_mode = 1'b0;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin
        bus.start = 1'b1;
        bus.value = 8'd7;
      end
      chk("ign_busy", obs, {2'b10, cur});
      tick();
      bus.start = 1'b0;
    end
    cur = {1'b0, 4'b0011, 12'h042};
    chk("ign_done", obs, {2'b11, cur});
    bus.start = 1'b1;
    bus.value = 8'd7;
    tick();
    bus.start = 1'b0;
    chk("ign_idle", obs, {2'b00, cur});
    run_conv(8'd7, 1'b0, {1'b0, 4'b0001, 12'h007}, "u7");

    // Reset in cycle 4 of a conversion aborts with no done.
    run_conv(8'd123, 1'b0, {1'b0, 4'b0111, 12'h123}, "u123");
    bus.value       = 8'd55;
    bus.signed_mode = 1'b0;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("abort_busy", obs, {2'b10, cur});
      if (c == 4) rst_n = 1'b0;
      tick();
    end
    cur = {1'b0, 4'b0001, 12'h000};
    chk("abort_reset", obs, {2'b00, cur});
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("abort_quiet", obs, {2'b00, cur});
    end
    run_conv(8'd55, 1'b0, {1'b0, 4'b0011, 12'h055}, "u55");

    // Outputs hold with no activity.
    run_conv(8'd200, 1'b0, {1'b0, 4'b0111, 12'h200}, "u200");
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("stable", obs, {2'b00, cur});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
